tx_bit_align_trng_gen: RTL and testbench
========================================

TX_BIT_ALIGN_TRNG_GEN -- requirements
Module: tx_bit_align_trng_gen

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, parallel lane word width toward the TX IOD serializer.
REQ-002 SHALL have parameter TRNG_PATTERN, default 8'hF0, training word sent during alignment.
REQ-003 SHALL have parameter IDLE_WORD, default 8'h00, word sent when no payload or not training.
REQ-004 SHALL have parameter MIN_TRNG_CYCLES, default 64, minimum TRAIN dwell in SCLK cycles.
REQ-005 SHALL have parameter TRNG_TIMEOUT, default 1024, TRAIN cycles before a retry.
REQ-006 SHALL have parameter GUARD_CYCLES, default 16, pattern cycles sent after remote done.
REQ-007 SHALL have parameter MAX_RETRIES, default 3, retries before ERR.
REQ-008 SCLK  input  1  sole clock; all logic on rising edge.
REQ-009 RESET  input  1  synchronous, active-high reset.
REQ-010 PLL_LOCK  input  1  TX PLL lock, synchronous to SCLK.
REQ-011 BIT_ALGN_DONE_IN  input  1  remote RX alignment done, pre-synchronized to SCLK.
REQ-012 BIT_ALGN_ERR_IN  input  1  remote RX alignment error, pre-synchronized.
REQ-013 TRNG_RSTRT  input  1  single-cycle pulse requesting retraining.
REQ-014 TX_DATA_IN  input  DATA_WIDTH  user payload word.
REQ-015 TX_DATA_VALID  input  1  payload valid.
REQ-016 TX_DATA_READY  output  1  payload accepted when VALID and READY high.
REQ-017 TX_DATA_OUT  output  DATA_WIDTH  registered word to serializer.
REQ-018 TRNG_ACTIVE  output  1  high in TRAIN or GUARD.
REQ-019 TRNG_DONE  output  1  high in DATA.
REQ-020 TRNG_ERR  output  1  high in ERR.
REQ-021 TRNG_RETRY_CNT  output  4  retries taken in current training session, saturating at 15.

Function
REQ-022 SHALL implement states IDLE, TRAIN, GUARD, DATA, ERR; state-derived outputs (READY, ACTIVE, DONE, ERR) SHALL be registered/decoded from current state, no input-to-output combinational path.
REQ-023 IDLE: TX_DATA_OUT=IDLE_WORD; PLL_LOCK high -> TRAIN next cycle, cycle counter and retry count cleared.
REQ-024 TRAIN: TX_DATA_OUT=TRNG_PATTERN every cycle; cycle counter increments from 0 each cycle.
REQ-025 BIT_ALGN_DONE_IN seen in TRAIN SHALL be latched; TRAIN -> GUARD on the first cycle with latch set and counter >= MIN_TRNG_CYCLES-1.
REQ-026 TRAIN with counter reaching TRNG_TIMEOUT-1 and no latched done, or BIT_ALGN_ERR_IN high: retry -- counter and done latch cleared, TRNG_RETRY_CNT +1, remain TRAIN; if retry count already equals MAX_RETRIES -> ERR instead.
REQ-027 Latched done and timeout/ERR_IN in the same cycle: done wins if MIN_TRNG_CYCLES met.
REQ-028 GUARD: TRNG_PATTERN sent for exactly GUARD_CYCLES cycles, then -> DATA; ERR_IN in GUARD ignored.
REQ-029 DATA: TX_DATA_READY=1; accepted word appears on TX_DATA_OUT the following cycle (latency 1); cycle with no accept drives IDLE_WORD.
REQ-030 ERR: TX_DATA_OUT=IDLE_WORD; held until TRNG_RSTRT or PLL_LOCK loss.
REQ-031 TRNG_RSTRT in TRAIN, GUARD, DATA or ERR -> TRAIN next cycle, counter, latch and retry count cleared; ignored in IDLE.
REQ-032 PLL_LOCK low in any state -> IDLE next cycle; dominates TRNG_RSTRT and all other events.
REQ-033 Counter width SHALL be clog2(TRNG_TIMEOUT) bits minimum; no wrap within TRAIN.

Reset
REQ-034 RESET high SHALL force IDLE, TX_DATA_OUT=IDLE_WORD, TX_DATA_READY/TRNG_ACTIVE/TRNG_DONE/TRNG_ERR=0, TRNG_RETRY_CNT=0, counter and latch cleared; RESET dominates all inputs, including mid-training or mid-payload.

Verification
REQ-035 Nominal: PLL_LOCK=1, DONE_IN at TRAIN cycle 100 -> 8'hF0 for 100+ cycles, 16 guard cycles, TRNG_DONE=1, READY=1.
REQ-036 Early done: DONE_IN pulse at TRAIN cycle 10 -> GUARD entered only after cycle 63, then DATA.
REQ-037 Timeout: DONE_IN never -> TRNG_RETRY_CNT 1,2,3 at 1024-cycle intervals, then TRNG_ERR=1, TX_DATA_OUT=8'h00.
REQ-038 Payload: in DATA, VALID words 8'hA5,8'h3C back-to-back -> appear on TX_DATA_OUT one cycle later, 8'h00 when VALID=0.
REQ-039 Lock loss: PLL_LOCK low in DATA coincident with TRNG_RSTRT -> IDLE, READY=0; lock restore -> TRAIN, retry count 0.
REQ-040 Reset mid-GUARD: RESET pulse -> all outputs at REQ-034 values next cycle.

Source files
------------

// File: rtl/tx_bit_align_trng_gen.sv
// rtl/tx_bit_align_trng_gen.sv - TX lane bit-alignment training word generator
//
// Purpose:
//    Drives the parallel word toward a TX serializer. After PLL lock it
//    sends a fixed training pattern until the remote receiver reports bit
//    alignment, then holds the pattern for a guard period before opening
//    the lane to user payload. Training that stalls is retried a bounded
//    number of times before the block parks in an error state.
//
// Ports:
//    i_sclk                sole clock, rising edge
//    i_reset               synchronous active-high reset
//    i_pll_lock            TX PLL lock (SCLK domain)
//    i_bit_algn_done_in    remote RX alignment done (pre-synchronized)
//    i_bit_algn_err_in     remote RX alignment error (pre-synchronized)
//    i_trng_rstrt          single-cycle retrain request
//    i_tx_data_in          user payload word
//    i_tx_data_valid       payload valid
//    o_tx_data_ready       payload accepted when valid and ready are high
//    o_tx_data_out         registered word to the serializer
//    o_trng_active         high in TRAIN or GUARD
//    o_trng_done           high in DATA
//    o_trng_err            high in ERR
//    o_trng_retry_cnt      retries taken in the current session (sat. 15)

module tx_bit_align_trng_gen #(
   parameter int                    DATA_WIDTH      = 8,
   parameter logic [DATA_WIDTH-1:0] TRNG_PATTERN    = 8'hF0,
   parameter logic [DATA_WIDTH-1:0] IDLE_WORD       = 8'h00,
   parameter int                    MIN_TRNG_CYCLES = 64,
   parameter int                    TRNG_TIMEOUT    = 1024,
   parameter int                    GUARD_CYCLES    = 16,
   parameter int                    MAX_RETRIES     = 3
) (
   input  logic                  i_sclk,
   input  logic                  i_reset,
   input  logic                  i_pll_lock,
   input  logic                  i_bit_algn_done_in,
   input  logic                  i_bit_algn_err_in,
   input  logic                  i_trng_rstrt,
   input  logic [DATA_WIDTH-1:0] i_tx_data_in,
   input  logic                  i_tx_data_valid,
   output logic                  o_tx_data_ready,
   output logic [DATA_WIDTH-1:0] o_tx_data_out,
   output logic                  o_trng_active,
   output logic                  o_trng_done,
   output logic                  o_trng_err,
   output logic [3:0]            o_trng_retry_cnt
);

   // The cycle counter is shared by TRAIN and GUARD, so it must cover the
   // larger of the two dwell limits.
   localparam int CNT_MAX = (TRNG_TIMEOUT > GUARD_CYCLES) ? TRNG_TIMEOUT : GUARD_CYCLES;
   localparam int CNT_W   = ($clog2(CNT_MAX) < 1) ? 1 : $clog2(CNT_MAX);

   localparam logic [CNT_W-1:0] MIN_M1   = CNT_W'(MIN_TRNG_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_M1   = CNT_W'(TRNG_TIMEOUT - 1);
   localparam logic [CNT_W-1:0] GUARD_M1 = CNT_W'(GUARD_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_TRAIN = 3'd1,
      ST_GUARD = 3'd2,
      ST_DATA  = 3'd3,
      ST_ERR   = 3'd4
   } state_t;

   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic                  r_done_lat;
   logic [3:0]            r_retry;
   logic [DATA_WIDTH-1:0] r_tx_data;

   state_t                w_nxt_state;
   logic [CNT_W-1:0]      w_nxt_cnt;
   logic                  w_nxt_done_lat;
   logic [3:0]            w_nxt_retry;
   logic [DATA_WIDTH-1:0] w_nxt_tx_data;
   logic                  w_accept;
   logic                  w_align_ok;
   logic                  w_retry_evt;

   // Ready is a pure decode of the state register, so the valid input never
   // reaches an output combinationally.
   assign w_accept    = (r_state == ST_DATA) && i_tx_data_valid;

   // Only the registered latch counts: a done pulse takes effect the cycle
   // after it is seen, which also keeps the GUARD entry point deterministic.
   assign w_align_ok  = r_done_lat && (r_cnt >= MIN_M1);

   // Timeout compares with >= so the counter can never wrap inside TRAIN,
   // even if the parameters put MIN_TRNG_CYCLES above TRNG_TIMEOUT.
   assign w_retry_evt = (r_cnt >= TMO_M1) || i_bit_algn_err_in;

   always_comb begin
      w_nxt_state    = r_state;
      w_nxt_cnt      = r_cnt;
      w_nxt_done_lat = r_done_lat;
      w_nxt_retry    = r_retry;
      w_nxt_tx_data  = IDLE_WORD;

      if (!i_pll_lock) begin
         // Lock loss beats everything, including a retrain request. The
         // retry count is kept for observation and cleared on leaving IDLE.
         w_nxt_state    = ST_IDLE;
         w_nxt_cnt      = '0;
         w_nxt_done_lat = 1'b0;
      end else if (i_trng_rstrt && (r_state != ST_IDLE)) begin
         w_nxt_state    = ST_TRAIN;
         w_nxt_cnt      = '0;
         w_nxt_done_lat = 1'b0;
         w_nxt_retry    = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               w_nxt_state    = ST_TRAIN;
               w_nxt_cnt      = '0;
               w_nxt_done_lat = 1'b0;
               w_nxt_retry    = '0;
            end

            ST_TRAIN: begin
               if (w_align_ok) begin
                  // Alignment wins over a same-cycle timeout or remote error.
                  w_nxt_state    = ST_GUARD;
                  w_nxt_cnt      = '0;
                  w_nxt_done_lat = 1'b0;
               end else if (w_retry_evt) begin
                  w_nxt_cnt      = '0;
                  w_nxt_done_lat = 1'b0;
                  if (int'(r_retry) >= MAX_RETRIES) begin
                     w_nxt_state = ST_ERR;
                  end else if (r_retry != 4'hF) begin
                     w_nxt_retry = r_retry + 4'd1;
                  end
               end else begin
                  w_nxt_cnt      = r_cnt + 1'b1;
                  w_nxt_done_lat = r_done_lat | i_bit_algn_done_in;
               end
            end

            ST_GUARD: begin
               // Remote error is deliberately ignored here: the far end has
               // already declared alignment and only needs settling time.
               if (r_cnt >= GUARD_M1) begin
                  w_nxt_state = ST_DATA;
                  w_nxt_cnt   = '0;
               end else begin
                  w_nxt_cnt = r_cnt + 1'b1;
               end
            end

            ST_DATA: begin
               w_nxt_state = ST_DATA;
            end

            ST_ERR: begin
               w_nxt_state = ST_ERR;
            end

            default: begin
               w_nxt_state    = ST_IDLE;
               w_nxt_cnt      = '0;
               w_nxt_done_lat = 1'b0;
               w_nxt_retry    = '0;
            end
         endcase
      end

      // The output word is chosen from the state being entered so that the
      // registered word lines up with the registered state. Payload accepted
      // on a cycle that leaves DATA is dropped in favour of the new state.
      case (w_nxt_state)
         ST_TRAIN, ST_GUARD: w_nxt_tx_data = TRNG_PATTERN;
         ST_DATA:            w_nxt_tx_data = w_accept ? i_tx_data_in : IDLE_WORD;
         default:            w_nxt_tx_data = IDLE_WORD;
      endcase
   end

   always_ff @(posedge i_sclk) begin
      if (i_reset) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_done_lat <= 1'b0;
         r_retry    <= '0;
         r_tx_data  <= IDLE_WORD;
      end else begin
         r_state    <= w_nxt_state;
         r_cnt      <= w_nxt_cnt;
         r_done_lat <= w_nxt_done_lat;
         r_retry    <= w_nxt_retry;
         r_tx_data  <= w_nxt_tx_data;
      end
   end

   assign o_tx_data_out    = r_tx_data;
   assign o_tx_data_ready  = (r_state == ST_DATA);
   assign o_trng_active    = (r_state == ST_TRAIN) || (r_state == ST_GUARD);
   assign o_trng_done      = (r_state == ST_DATA);
   assign o_trng_err       = (r_state == ST_ERR);
   assign o_trng_retry_cnt = r_retry;

endmodule

// File: tb/tb_tx_bit_align_trng_gen.sv
// tb/tb_tx_bit_align_trng_gen.sv - directed table-driven bench for tx_bit_align_trng_gen

module tb_tx_bit_align_trng_gen;

   logic       clk = 1'b0;
   logic       rst;
   logic       lock;
   logic       done_in;
   logic       err_in;
   logic       rstrt;
   logic [7:0] din;
   logic       valid;
   logic       ready;
   logic [7:0] dout;
   logic       active;
   logic       tdone;
   logic       terr;
   logic [3:0] retry;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   tx_bit_align_trng_gen dut (
      .i_sclk             (clk),
      .i_reset            (rst),
      .i_pll_lock         (lock),
      .i_bit_algn_done_in (done_in),
      .i_bit_algn_err_in  (err_in),
      .i_trng_rstrt       (rstrt),
      .i_tx_data_in       (din),
      .i_tx_data_valid    (valid),
      .o_tx_data_ready    (ready),
      .o_tx_data_out      (dout),
      .o_trng_active      (active),
      .o_trng_done        (tdone),
      .o_trng_err         (terr),
      .o_trng_retry_cnt   (retry)
   );

   typedef struct {
      logic       rst, lock, done, err, rstrt, valid;
      logic [7:0] data;
      int         n;
      logic [7:0] e_out;
      logic       e_rdy, e_act, e_done, e_err;
      logic [3:0] e_retry;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic r, input logic l, input logic d, input logic e,
                      input logic rs, input logic v, input logic [7:0] dat, input int n,
                      input logic [7:0] eo, input logic erd, input logic ea,
                      input logic ed, input logic ee, input logic [3:0] ert);
      vec_t t;
      t.rst = r; t.lock = l; t.done = d; t.err = e; t.rstrt = rs; t.valid = v;
      t.data = dat; t.n = n; t.e_out = eo; t.e_rdy = erd; t.e_act = ea;
      t.e_done = ed; t.e_err = ee; t.e_retry = ert;
      tbl.push_back(t);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input int idx, input logic [7:0] got, input logic [7:0] want);
      checks++;
      if (got !== want) begin
         errors++;
         $display("FAIL %s rec%0d: got %h want %h", name, idx, got, want);
      end
   endtask

   initial begin
      rst = 1'b1; lock = 1'b0; done_in = 1'b0; err_in = 1'b0;
      rstrt = 1'b0; din = 8'h00; valid = 1'b0;

      //   rst lk dn er rs v  data  n     out  rdy act dn er rt
      add(1, 0, 0, 0, 0, 0, 8'h00, 2,    8'h00, 0, 0, 0, 0, 0);  // 0 reset
      add(0, 0, 0, 0, 0, 0, 8'h00, 3,    8'h00, 0, 0, 0, 0, 0);  // 1 idle, no lock
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 2 train c0
      add(0, 1, 0, 0, 0, 0, 8'h00, 100,  8'hF0, 0, 1, 0, 0, 0);  // 3 c100
      add(0, 1, 1, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 4 done seen
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 5 guard g0
      add(0, 1, 0, 0, 0, 0, 8'h00, 15,   8'hF0, 0, 1, 0, 0, 0);  // 6 g15
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'h00, 1, 0, 1, 0, 0);  // 7 data
      add(0, 1, 0, 0, 0, 1, 8'hA5, 1,    8'hA5, 1, 0, 1, 0, 0);  // 8
      add(0, 1, 0, 0, 0, 1, 8'h3C, 1,    8'h3C, 1, 0, 1, 0, 0);  // 9
      add(0, 1, 0, 0, 0, 0, 8'h77, 1,    8'h00, 1, 0, 1, 0, 0);  // 10 no valid
      add(0, 1, 0, 0, 0, 1, 8'h5A, 1,    8'h5A, 1, 0, 1, 0, 0);  // 11
      add(0, 0, 0, 0, 1, 1, 8'h99, 1,    8'h00, 0, 0, 0, 0, 0);  // 12 lock loss + rstrt
      add(0, 0, 0, 0, 0, 0, 8'h00, 2,    8'h00, 0, 0, 0, 0, 0);  // 13
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 14 train c0
      add(0, 1, 0, 0, 0, 0, 8'h00, 10,   8'hF0, 0, 1, 0, 0, 0);  // 15 c10
      add(0, 1, 1, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 16 early done
      add(0, 1, 0, 0, 0, 0, 8'h00, 52,   8'hF0, 0, 1, 0, 0, 0);  // 17 c63
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 18 guard g0
      add(0, 1, 0, 1, 0, 0, 8'h00, 15,   8'hF0, 0, 1, 0, 0, 0);  // 19 err ignored in guard
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'h00, 1, 0, 1, 0, 0);  // 20 data
      add(0, 1, 0, 0, 1, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 21 rstrt -> train
      add(0, 1, 0, 1, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 1);  // 22 err retry
      add(0, 1, 0, 1, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 2);  // 23
      add(0, 1, 0, 0, 1, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 24 rstrt clears
      add(0, 1, 0, 0, 0, 0, 8'h00, 1023, 8'hF0, 0, 1, 0, 0, 0);  // 25 c1023
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 1);  // 26 timeout 1
      add(0, 1, 0, 0, 0, 0, 8'h00, 1023, 8'hF0, 0, 1, 0, 0, 1);  // 27
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 2);  // 28 timeout 2
      add(0, 1, 0, 0, 0, 0, 8'h00, 1024, 8'hF0, 0, 1, 0, 0, 3);  // 29 timeout 3
      add(0, 1, 0, 0, 0, 0, 8'h00, 1023, 8'hF0, 0, 1, 0, 0, 3);  // 30
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'h00, 0, 0, 0, 1, 3);  // 31 err state
      add(0, 1, 0, 0, 0, 0, 8'h00, 5,    8'h00, 0, 0, 0, 1, 3);  // 32 held
      add(0, 1, 0, 0, 1, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 33 rstrt from err
      add(0, 1, 1, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 34
      add(0, 1, 0, 0, 0, 0, 8'h00, 62,   8'hF0, 0, 1, 0, 0, 0);  // 35 c63
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 36 guard g0
      add(0, 1, 0, 1, 0, 0, 8'h00, 5,    8'hF0, 0, 1, 0, 0, 0);  // 37 g5
      add(1, 1, 0, 0, 0, 0, 8'h00, 1,    8'h00, 0, 0, 0, 0, 0);  // 38 reset mid-guard
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 39
      add(0, 1, 1, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 40
      add(0, 1, 0, 0, 0, 0, 8'h00, 61,   8'hF0, 0, 1, 0, 0, 0);  // 41 c62
      add(0, 1, 0, 1, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 1);  // 42 min not met -> retry
      add(0, 1, 1, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 1);  // 43
      add(0, 1, 0, 0, 0, 0, 8'h00, 62,   8'hF0, 0, 1, 0, 0, 1);  // 44 c63
      add(0, 1, 0, 1, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 1);  // 45 done wins
      add(0, 1, 0, 0, 0, 0, 8'h00, 16,   8'h00, 1, 0, 1, 0, 1);  // 46 data
      add(0, 0, 0, 0, 0, 0, 8'h00, 1,    8'h00, 0, 0, 0, 0, 1);  // 47 lock loss
      add(0, 1, 0, 0, 0, 0, 8'h00, 1,    8'hF0, 0, 1, 0, 0, 0);  // 48 retry cleared

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; lock = tbl[i].lock; done_in = tbl[i].done;
         err_in = tbl[i].err; rstrt = tbl[i].rstrt; valid = tbl[i].valid;
         din = tbl[i].data;
         repeat (tbl[i].n) step();
         chk("data_out", i, dout, tbl[i].e_out);
         chk("ready", i, {7'd0, ready}, {7'd0, tbl[i].e_rdy});
         chk("active", i, {7'd0, active}, {7'd0, tbl[i].e_act});
         chk("done", i, {7'd0, tdone}, {7'd0, tbl[i].e_done});
         chk("err", i, {7'd0, terr}, {7'd0, tbl[i].e_err});
         chk("retry", i, {4'd0, retry}, {4'd0, tbl[i].e_retry});
      end

      // Pattern must be held on every cycle of TRAIN and GUARD: done seen
      // at c0, GUARD at c64..c79, DATA from c80.
      rst = 1'b0; lock = 1'b1; err_in = 1'b0; rstrt = 1'b0; valid = 1'b0;
      done_in = 1'b1;
      step();
      done_in = 1'b0;
      for (int c = 1; c < 80; c++) begin
         chk("hold_pattern", c, dout, 8'hF0);
         chk("hold_active", c, {7'd0, active}, 8'd1);
         step();
      end
      chk("seq_done", 80, {7'd0, tdone}, 8'd1);
      chk("seq_ready", 80, {7'd0, ready}, 8'd1);

      // Reset while a payload word is being offered.
      valid = 1'b1; din = 8'hC3; rst = 1'b1;
      step();
      chk("rst_payload_out", 0, dout, 8'h00);
      chk("rst_payload_ready", 0, {7'd0, ready}, 8'd0);
      chk("rst_payload_done", 0, {7'd0, tdone}, 8'd0);
      rst = 1'b0; valid = 1'b0;
      step();
      chk("after_rst_train", 0, dout, 8'hF0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
